fetch_buffer: RTL and testbench

Decoupling queue on the consumer side of the instruction fetch unit in the P5 pipelined MIPS core. Each cycle it captures the `{pc, instr}` pair presented by `ifu` and drives `ifu.enable` so the PC advances only when there is space. It delivers entries in order to the decode stage through a valid/ready handshake. A branch/jump redirect flushes all queued entries.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_buffer_mem.sv | 34 +++
 rtl/fetch_buffer.sv | 100 ++++++++++
 tb/tb_fetch_buffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch buffer
// entry layout, widths and the IFU reset PC
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// fetch_buffer_mem: DEPTH x fetch_entry_t register array
// sync write, async read, sync reset-to-zero
module fetch_buffer_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  fetch_entry_t               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output fetch_entry_t               rdata
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  // next array contents: write one slot when enabled
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // storage register, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order queue between IFU and decode, flushed on redirect
// optional zero-latency bypass under FETCH_BUFFER_BYPASS_EN
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_W-1:0]       fetch_instr,
  input  logic [PC_W-1:0]          fetch_pc,
  output logic                     fetch_enable,
  input  logic                     flush,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic [INSTR_W-1:0]       d_instr,
  output logic [PC_W-1:0]          d_pc,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic push, pop, bypass;
  logic wr_en, rd_en;
  fetch_entry_t wr_entry, rd_entry;

  assign fetch_enable = (count_q != FULL_CNT) | flush;
  assign push         = fetch_enable & ~flush;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = (count_q == '0) & push & ~reset;
`else
  assign bypass = 1'b0;
`endif

  assign d_valid = (count_q != '0) | bypass;
  assign d_instr = bypass ? fetch_instr : rd_entry.instr;
  assign d_pc    = bypass ? fetch_pc    : rd_entry.pc;
  assign pop     = d_valid & d_ready & ~flush;

  // a bypassed pair taken by decode never touches storage
  assign wr_en = push & ~(bypass & d_ready);
  assign rd_en = pop & ~bypass;

  assign wr_entry = '{pc: fetch_pc, instr: fetch_instr};
  assign level    = count_q;

  fetch_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  // pointer/count next state; flush clears everything
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // pointer/count registers; reset dominates flush
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a queue scoreboard
// IFU is modelled here; a monitor checks each decode handshake
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_instr = '0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_enable;
  logic        flush = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;
  int mcount = 0;
  logic [31:0] ifu_pc = RESET_PC;
  fetch_entry_t exp_q [$];

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_instr  (fetch_instr),
    .fetch_pc     (fetch_pc),
    .fetch_enable (fetch_enable),
    .flush        (flush),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_instr      (d_instr),
    .d_pc         (d_pc),
    .level        (level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F00;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // monitor: every accepted head entry must match the scoreboard front
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && d_valid && d_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected act=%h exp=none", d_pc);
        end else begin
          e = exp_q.pop_front();
          check("d_pc", d_pc, e.pc);
          check("d_instr", d_instr, e.instr);
        end
      end
    end
  end

  task automatic do_reset(input int n, input logic fl);
    reset = 1'b1;
    flush = fl;
    d_ready = 1'b1;
    ifu_pc = RESET_PC;
    fetch_pc = ifu_pc;
    fetch_instr = instr_of(ifu_pc);
    repeat (n) @(posedge clk);
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_pc", d_pc, 32'd0);
    check("rst_d_instr", d_instr, 32'd0);
    check("rst_fetch_enable", 32'(fetch_enable), 32'd1);
    exp_q.delete();
    mcount = 0;
    reset = 1'b0;
    flush = 1'b0;
  endtask

  task automatic step(input logic rdy, input logic fl,
                      input logic [31:0] tgt);
    logic fe, pu, byp, po, wr, rd;
    fetch_entry_t ent;
    d_ready = rdy;
    flush = fl;
    fetch_pc = ifu_pc;
    fetch_instr = instr_of(ifu_pc);
    ent = '{pc: ifu_pc, instr: instr_of(ifu_pc)};
    fe = (mcount != DEPTH) || fl;
    pu = fe && !fl;
    byp = (BYP != 0) && (mcount == 0) && pu;
    if (byp) exp_q.push_back(ent);
    @(negedge clk);
    #1;
    check("fetch_enable", 32'(fetch_enable), 32'(fe));
    check("level", 32'(level), 32'(mcount));
    check("d_valid", 32'(d_valid), 32'((mcount != 0) || byp));
    po = ((mcount != 0) || byp) && rdy && !fl;
    wr = pu && !(byp && rdy);
    rd = po && !byp;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (pu && !byp) exp_q.push_back(ent);
      if (wr) mcount++;
      if (rd) mcount--;
    end
    if (fe) ifu_pc = fl ? tgt : ifu_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset(2, 1'b0);

    // stream with decode always ready
    repeat (4) step(1'b1, 1'b0, '0);
    check("stream_level", 32'(level), BYP ? 32'd0 : 32'd1);

    // fill from empty with decode stalled
    do_reset(1, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0);
    check("full_level", 32'(level), 32'd4);
    check("full_fe", 32'(fetch_enable), 32'd0);
    check("frozen_pc", ifu_pc, 32'h0000_3010);

    // drain while full, refill behind it
    repeat (4) step(1'b1, 1'b0, '0);
    check("drain_level", 32'(level), 32'd3);

    // flush with simultaneous push and pop
    step(1'b1, 1'b1, 32'h0000_3100);
    check("flush_level", 32'(level), 32'd0);
    check("flush_d_valid", 32'(d_valid), 32'd0);
    step(1'b0, 1'b0, '0);
    check("flush_target", d_pc, 32'h0000_3100);
    step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);
    check("pre_rst_level", 32'(level), 32'd3);

    // reset together with flush mid-operation
    do_reset(1, 1'b1);
    repeat (3) step(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
